// File: rtl/nand_cmd_dispatch_pkg.sv
// Shared NAND definitions: sequencer opcodes, host request encodings and
// the dispatcher state encoding.
package nand_cmd_dispatch_pkg;

  localparam logic [7:0] CMD_NONE        = 8'h00;
  localparam logic [7:0] CMD_READ_ID     = 8'h90;
  localparam logic [7:0] CMD_RESET       = 8'hFF;
  localparam logic [7:0] CMD_READ_STATUS = 8'h70;

  typedef enum logic [1:0] {
    OP_READ_ID     = 2'b00,
    OP_RESET       = 2'b01,
    OP_READ_STATUS = 2'b10,
    OP_RSVD        = 2'b11
  } req_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_RB,
    ST_BUSY,
    ST_RB_POST,
    ST_GAP,
    ST_RESP
  } disp_state_e;

  function automatic logic [7:0] op_to_cmd(input req_op_e op);
    case (op)
      OP_READ_ID:     op_to_cmd = CMD_READ_ID;
      OP_RESET:       op_to_cmd = CMD_RESET;
      OP_READ_STATUS: op_to_cmd = CMD_READ_STATUS;
      default:        op_to_cmd = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/nand_cmd_dispatch_if.sv
// Host request/response and sequencer/flash signals of the command dispatcher.
// slave = dispatcher side, master = host plus sequencer side.
interface nand_cmd_dispatch_if;
  import nand_cmd_dispatch_pkg::*;

  logic        req_valid;
  req_op_e     req_op;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_error;
  logic [31:0] rsp_data;
  logic [7:0]  seq_cmd;
  logic        seq_done;
  logic        id_byte_valid;
  logic [7:0]  id_byte;
  logic        nand_rb;

  modport slave (
    input  req_valid, req_op, rsp_ready, seq_done, id_byte_valid, id_byte, nand_rb,
    output req_ready, rsp_valid, rsp_error, rsp_data, seq_cmd
  );

  modport master (
    output req_valid, req_op, rsp_ready, seq_done, id_byte_valid, id_byte, nand_rb,
    input  req_ready, rsp_valid, rsp_error, rsp_data, seq_cmd
  );
endinterface

// File: rtl/nand_cmd_dispatch.sv
// NAND command front-end: waits for R/B#, issues one opcode to the sequencer,
// collects returned bytes and produces a single response word with error flag.
module nand_cmd_dispatch
  import nand_cmd_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int ID_BYTES       = 4,
  parameter int GAP_CYCLES     = 2
) (
  input  logic             clk,
  input  logic             reset,
  nand_cmd_dispatch_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
  localparam logic [2:0]    ID_LIMIT   = 3'(ID_BYTES);

  disp_state_e   r_state, w_state_next;
  req_op_e       r_op, w_op_next;
  logic [TW-1:0] r_timer, w_timer_next;
  logic [GW-1:0] r_gap_cnt, w_gap_next;
  logic [7:0]    r_seq_cmd, w_cmd_next;
  logic          r_err, w_err_next;
  logic          r_out_en;
  logic [2:0]    r_byte_cnt;
  logic [31:0]   r_data;
  logic          w_clear;
  logic          w_capture;
  logic          w_timeout;
  logic          w_short;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_op      <= OP_READ_ID;
      r_timer   <= '0;
      r_gap_cnt <= '0;
      r_seq_cmd <= CMD_NONE;
      r_err     <= 1'b0;
      r_out_en  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_op      <= w_op_next;
      r_timer   <= w_timer_next;
      r_gap_cnt <= w_gap_next;
      r_seq_cmd <= w_cmd_next;
      r_err     <= w_err_next;
      r_out_en  <= 1'b1;
    end
  end

  assign w_timeout = (r_timer == TIMER_LAST);

  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_timer_next = r_timer;
    w_gap_next   = r_gap_cnt;
    w_cmd_next   = r_seq_cmd;
    w_err_next   = r_err;
    w_clear      = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_out_en keeps the first cycle after reset release non-accepting
        if (r_out_en && bus.req_valid) begin
          w_op_next    = bus.req_op;
          w_timer_next = '0;
          w_clear      = 1'b1;
          w_err_next   = (bus.req_op == OP_RSVD);
          w_state_next = (bus.req_op == OP_RSVD) ? ST_RESP : ST_WAIT_RB;
        end
      end
      ST_WAIT_RB: begin
        w_timer_next = r_timer + 1'b1;
        if (w_timeout) begin
          w_err_next   = 1'b1;
          w_cmd_next   = CMD_NONE;
          w_gap_next   = '0;
          w_state_next = ST_GAP;
        end else if (bus.nand_rb) begin
          w_cmd_next   = op_to_cmd(r_op);
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        w_timer_next = r_timer + 1'b1;
        w_capture    = 1'b1;
        // a done pulse on the timeout cycle still counts as a completed command
        if (bus.seq_done) begin
          w_cmd_next   = CMD_NONE;
          w_gap_next   = '0;
          w_state_next = (r_op == OP_RESET) ? ST_RB_POST : ST_GAP;
        end else if (w_timeout) begin
          w_err_next   = 1'b1;
          w_cmd_next   = CMD_NONE;
          w_gap_next   = '0;
          w_state_next = ST_GAP;
        end
      end
      ST_RB_POST: begin
        w_timer_next = r_timer + 1'b1;
        if (w_timeout) begin
          w_err_next   = 1'b1;
          w_gap_next   = '0;
          w_state_next = ST_GAP;
        end else if (bus.nand_rb) begin
          w_gap_next   = '0;
          w_state_next = ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == GAP_LAST) w_state_next = ST_RESP;
        else                       w_gap_next   = r_gap_cnt + 1'b1;
      end
      ST_RESP: begin
        if (bus.rsp_ready) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Byte lanes fill from 0 upward; the count parks at 4 and later bytes drop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= '0;
      r_data     <= '0;
    end else if (w_clear) begin
      r_byte_cnt <= '0;
      r_data     <= '0;
    end else if (w_capture && bus.id_byte_valid && !r_byte_cnt[2]) begin
      r_data[{r_byte_cnt[1:0], 3'b000} +: 8] <= bus.id_byte;
      r_byte_cnt <= r_byte_cnt + 3'd1;
    end
  end

  assign w_short = ((r_op == OP_READ_ID) && (r_byte_cnt < ID_LIMIT)) ||
                   ((r_op == OP_READ_STATUS) && (r_byte_cnt == 3'd0));

  assign bus.req_ready = r_out_en && (r_state == ST_IDLE);
  assign bus.rsp_valid = (r_state == ST_RESP);
  assign bus.rsp_error = (r_state == ST_RESP) && (r_err || w_short);
  assign bus.rsp_data  = r_data;
  assign bus.seq_cmd   = r_seq_cmd;

endmodule

// File: tb/tb_nand_cmd_dispatch.sv
// Scoreboarded bench for nand_cmd_dispatch: expected responses are queued when
// a request is issued and compared when the response handshake happens.
module tb_nand_cmd_dispatch;
  import nand_cmd_dispatch_pkg::*;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb_q[$];

  nand_cmd_dispatch_if bus ();

  nand_cmd_dispatch #(
    .TIMEOUT_CYCLES(64),
    .ID_BYTES      (4),
    .GAP_CYCLES    (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Response monitor, sampled mid-low-phase so inputs driven at negedge are settled.
  always @(negedge clk) begin
    #2;
    if (!reset && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        check_val("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t ex;
        ex = sb_q.pop_front();
        check_val("rsp_data", bus.rsp_data, ex.d);
        check_val("rsp_error", 32'(bus.rsp_error), 32'(ex.e));
        $display("rsp: data=0x%08h err=%0d", bus.rsp_data, bus.rsp_error);
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < 200 && !bus.req_ready; i++) @(negedge clk);
    if (!bus.req_ready) check_val("req_ready_wait", 32'd0, 32'd1);
  endtask

  task automatic issue(input req_op_e op, input logic [31:0] d, input logic e, input logic push);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    if (push) sb_q.push_back('{d: d, e: e});
    $display("req: op=%0d", op);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_cmd(input string tag, input logic [7:0] exp);
    for (int i = 0; i < 100 && bus.seq_cmd !== exp; i++) @(negedge clk);
    check_val(tag, 32'(bus.seq_cmd), 32'(exp));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic done);
    bus.id_byte_valid = 1'b1;
    bus.id_byte       = b;
    bus.seq_done      = done;
    @(negedge clk);
    bus.id_byte_valid = 1'b0;
    bus.seq_done      = 1'b0;
  endtask

  task automatic pulse_done();
    bus.seq_done = 1'b1;
    @(negedge clk);
    bus.seq_done = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && sb_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check_val(tag, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.req_valid     = 1'b0;
    bus.req_op        = OP_READ_ID;
    bus.rsp_ready     = 1'b1;
    bus.seq_done      = 1'b0;
    bus.id_byte_valid = 1'b0;
    bus.id_byte       = 8'h00;
    bus.nand_rb       = 1'b1;

    // reset values
    repeat (3) @(negedge clk);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_val("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("rst_seq_cmd", 32'(bus.seq_cmd), 32'd0);
    check_val("rst_rsp_data", bus.rsp_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // READ_ID, four bytes, last byte alongside seq_done
    issue(OP_READ_ID, 32'h9551D3EC, 1'b0, 1'b1);
    check_val("rid_cmd_pre", 32'(bus.seq_cmd), 32'h00);
    @(negedge clk);
    check_val("rid_cmd_lat", 32'(bus.seq_cmd), 32'h90);
    send_byte(8'hEC, 1'b0);
    send_byte(8'hD3, 1'b0);
    send_byte(8'h51, 1'b0);
    send_byte(8'h95, 1'b1);
    check_val("rid_cmd_off", 32'(bus.seq_cmd), 32'h00);
    check_val("rid_lat0", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_val("rid_lat1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check_val("rid_lat2", 32'(bus.rsp_valid), 32'd1);
    drain("rid_drain");

    // READ_STATUS held off by R/B# for 20 cycles
    bus.nand_rb = 1'b0;
    issue(OP_READ_STATUS, 32'h000000E0, 1'b0, 1'b1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.seq_cmd !== 8'h00) n++;
      @(negedge clk);
    end
    check_val("st_cmd_held", 32'(n), 32'd0);
    bus.nand_rb = 1'b1;
    @(negedge clk);
    check_val("st_cmd", 32'(bus.seq_cmd), 32'h70);
    send_byte(8'hE0, 1'b0);
    pulse_done();
    drain("st_drain");

    // RESET op waits for R/B# after done
    issue(OP_RESET, 32'h0, 1'b0, 1'b1);
    wait_cmd("rst_op_cmd", 8'hFF);
    bus.seq_done = 1'b1;
    bus.nand_rb  = 1'b0;
    @(negedge clk);
    bus.seq_done = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.rsp_valid) n++;
      @(negedge clk);
    end
    check_val("rst_op_wait_rb", 32'(n), 32'd0);
    bus.nand_rb = 1'b1;
    drain("rst_op_drain");

    // READ_ID with no done: timer aborts after 63 cycles of command
    issue(OP_READ_ID, 32'h0, 1'b1, 1'b1);
    wait_cmd("to_cmd", 8'h90);
    n = 0;
    while (bus.seq_cmd === 8'h90 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check_val("to_len", 32'(n), 32'd63);
    check_val("to_cmd_off", 32'(bus.seq_cmd), 32'h00);
    drain("to_drain");

    // short READ_ID
    issue(OP_READ_ID, 32'h00002211, 1'b1, 1'b1);
    wait_cmd("short_cmd", 8'h90);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_done();
    drain("short_drain");

    // reserved op: immediate error, no command
    issue(OP_RSVD, 32'h0, 1'b1, 1'b1);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.seq_cmd !== 8'h00) n++;
      @(negedge clk);
    end
    check_val("rsvd_no_cmd", 32'(n), 32'd0);
    drain("rsvd_drain");

    // READ_STATUS with extra bytes (saturation) and a stalled host
    bus.rsp_ready = 1'b0;
    issue(OP_READ_STATUS, 32'hA4A3A2A1, 1'b0, 1'b1);
    wait_cmd("sat_cmd", 8'h70);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hA2, 1'b0);
    send_byte(8'hA3, 1'b0);
    send_byte(8'hA4, 1'b0);
    send_byte(8'hA5, 1'b1);
    for (int i = 0; i < 20 && !bus.rsp_valid; i++) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val("hold_valid", 32'(bus.rsp_valid), 32'd1);
      check_val("hold_data", bus.rsp_data, 32'hA4A3A2A1);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check_val("hold_drop", 32'(bus.rsp_valid), 32'd0);
    drain("sat_drain");

    // reset mid-BUSY: no response, outputs cleared at once
    bus.rsp_ready = 1'b0;
    issue(OP_READ_ID, 32'h0, 1'b0, 1'b0);
    wait_cmd("abort_cmd", 8'h90);
    send_byte(8'h33, 1'b0);
    reset = 1'b1;
    #1;
    check_val("abort_seq_cmd", 32'(bus.seq_cmd), 32'h00);
    check_val("abort_req_ready", 32'(bus.req_ready), 32'd0);
    check_val("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_val("abort_rsp_error", 32'(bus.rsp_error), 32'd0);
    check_val("abort_rsp_data", bus.rsp_data, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("rel_ready_low", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check_val("rel_ready_high", 32'(bus.req_ready), 32'd1);
    bus.rsp_ready = 1'b1;
    issue(OP_READ_STATUS, 32'h0000005A, 1'b0, 1'b1);
    wait_cmd("rel_cmd", 8'h70);
    send_byte(8'h5A, 1'b1);
    drain("rel_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
